// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and types for the instruction-fetch stage.
//   PC_W / INSTR_W / DEPTH / HALT_INSTR : default geometry and halt encoding
//   fetch_entry_t                        : one prefetch-queue entry {pc, instr}
//   CNT_W                                : width of a queue occupancy count
package fetch_pkg;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 4;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous prefetch queue with first-word-fall-through head.
//   CLK, reset_n : clock and asynchronous active-low reset
//   push/push_data : write one entry (ignored when full without a same-cycle pop)
//   pop            : drop the head (ignored when empty)
//   flush          : empty the queue; wins over push/pop
//   head, count    : current head entry (combinational) and occupancy
module fetch_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = pop && (r_count != '0) && !flush;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign w_push = push && !flush && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the instruction ROM and decode.
//   CLK, reset_n, start          : clock, async active-low reset, sync init
//   imem_req/imem_addr/imem_data : synchronous ROM port (data one cycle after req)
//   instr/instr_pc/instr_valid/instr_ready : valid/ready handshake to decode
//   redirect_en/redirect_target  : taken branch/jump, flushes the queue
//   halt, cycle_ct               : sticky done flag and saturating cycle counter
module fetch_unit #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int DEPTH   = fetch_pkg::DEPTH,
    parameter int CT_W    = 16,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               halt,
    output logic [CT_W-1:0]    cycle_ct
);
    import fetch_pkg::*;

    localparam int QCW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_inflight;
    logic            r_req_epoch;
    logic            r_epoch;
    logic            r_stopped;
    logic            r_halt;
    logic [CT_W-1:0] r_cycle_ct;

    logic [QCW-1:0]          w_count;
    logic [QCW-1:0]          w_occ;
    logic [PC_W+INSTR_W-1:0] w_head;
    logic                    w_resp;
    logic                    w_accept;
    logic                    w_halt_accept;
    logic                    w_redirect;
    logic                    w_push;
    logic                    w_flush;

    // Credit: queued words plus the outstanding one never exceed DEPTH.
    assign w_occ     = w_count + QCW'(r_inflight);
    assign imem_req  = reset_n && !start && !r_stopped && !r_halt && (w_occ < QCW'(DEPTH));
    assign imem_addr = r_fetch_pc;

    // A response tagged with an older epoch was issued before a redirect: drop it.
    assign w_resp        = r_inflight && (r_req_epoch == r_epoch);
    assign w_accept      = instr_valid && instr_ready;
    assign w_halt_accept = w_accept && (instr == HALT_INSTR);
    assign w_redirect    = redirect_en && !r_halt && !w_halt_accept;
    assign w_push        = w_resp && !w_redirect;
    assign w_flush       = w_redirect || start;

    fetch_fifo #(
        .DW    (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({r_inflight_pc, imem_data}),
        .pop       (w_accept),
        .flush     (w_flush),
        .head      (w_head),
        .count     (w_count)
    );

    assign {instr_pc, instr} = w_head;
    assign instr_valid       = !r_halt && (w_count != '0);
    assign halt              = r_halt;
    assign cycle_ct          = r_cycle_ct;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_req_epoch   <= 1'b0;
            r_epoch       <= 1'b0;
            r_stopped     <= 1'b0;
            r_halt        <= 1'b0;
            r_cycle_ct    <= '0;
        end else if (start) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_req_epoch   <= 1'b0;
            r_epoch       <= 1'b0;
            r_stopped     <= 1'b0;
            r_halt        <= 1'b0;
            r_cycle_ct    <= '0;
        end else begin
            if (!r_halt && (r_cycle_ct != {CT_W{1'b1}})) begin
                r_cycle_ct <= r_cycle_ct + CT_W'(1);
            end
            if (w_halt_accept) begin
                r_halt <= 1'b1;
            end
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inflight_pc <= r_fetch_pc;
                // Tag with the epoch before any same-cycle flip so it gets squashed.
                r_req_epoch   <= r_epoch;
            end
            if (w_redirect) begin
                r_epoch    <= ~r_epoch;
                r_fetch_pc <= redirect_target;
                r_stopped  <= 1'b0;
            end else begin
                if (imem_req) begin
                    r_fetch_pc <= r_fetch_pc + PC_W'(1);
                end
                if (w_push && (imem_data == HALT_INSTR)) begin
                    r_stopped <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic       one = 1'b1;
    logic       zero = 1'b0;
    logic [7:0] zero8 = 8'h00;

    // DUT0: default parameters, driven by the directed tests
    logic       req0, valid0, ready0, redir0, halt0;
    logic [7:0] addr0, ipc0, target0;
    logic [8:0] data0, instr0;
    logic [15:0] ct0;
    logic [8:0] rom0 [256];

    // DUT1: RESET_PC = FE, always ready
    logic       req1, valid1, halt1;
    logic [7:0] addr1, ipc1;
    logic [8:0] data1, instr1;
    logic [15:0] ct1;

    // DUT2: CT_W = 4, always ready
    logic       req2, valid2, halt2;
    logic [7:0] addr2, ipc2;
    logic [8:0] data2, instr2;
    logic [3:0] ct2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        data0 <= rom0[addr0];
        data1 <= {1'b0, addr1};
        data2 <= {1'b0, addr2};
    end

    fetch_unit u_dut0 (
        .CLK(clk), .reset_n(rst_n), .start(st),
        .imem_req(req0), .imem_addr(addr0), .imem_data(data0),
        .instr(instr0), .instr_pc(ipc0), .instr_valid(valid0), .instr_ready(ready0),
        .redirect_en(redir0), .redirect_target(target0),
        .halt(halt0), .cycle_ct(ct0)
    );

    fetch_unit #(.RESET_PC(8'hFE)) u_dut1 (
        .CLK(clk), .reset_n(rst_n), .start(st),
        .imem_req(req1), .imem_addr(addr1), .imem_data(data1),
        .instr(instr1), .instr_pc(ipc1), .instr_valid(valid1), .instr_ready(one),
        .redirect_en(zero), .redirect_target(zero8),
        .halt(halt1), .cycle_ct(ct1)
    );

    fetch_unit #(.CT_W(4)) u_dut2 (
        .CLK(clk), .reset_n(rst_n), .start(st),
        .imem_req(req2), .imem_addr(addr2), .imem_data(data2),
        .instr(instr2), .instr_pc(ipc2), .instr_valid(valid2), .instr_ready(one),
        .redirect_en(zero), .redirect_target(zero8),
        .halt(halt2), .cycle_ct(ct2)
    );

    // Leaves the bench at a falling edge with reset just released: cycle 0 starts here.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ready0 = 1'b1; redir0 = 1'b0; target0 = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req0 !== 1'b0) begin n_bad++; $display("FAIL reset_req0 got %b want 0", req0); end
        n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid0 got %b want 0", valid0); end
        n_cmp++; if (halt0 !== 1'b0) begin n_bad++; $display("FAIL reset_halt0 got %b want 0", halt0); end
        n_cmp++; if (ct0 !== 16'd0) begin n_bad++; $display("FAIL reset_ct0 got %0d want 0", ct0); end
        n_cmp++; if (addr1 !== 8'hFE) begin n_bad++; $display("FAIL reset_addr1 got %h want fe", addr1); end
        n_cmp++; if (req2 !== 1'b0) begin n_bad++; $display("FAIL reset_req2 got %b want 0", req2); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_stream();
        ready0 = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (req0 !== 1'b1 || addr0 !== 8'(c)) begin
                n_bad++; $display("FAIL stream_req c=%0d got req=%b addr=%h want 1/%h", c, req0, addr0, 8'(c));
            end
            n_cmp++;
            if (c < 2) begin
                if (valid0 !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid c=%0d got %b want 0", c, valid0); end
            end else if (valid0 !== 1'b1 || ipc0 !== 8'(c-2) || instr0 !== 9'(c-2)) begin
                n_bad++; $display("FAIL stream_head c=%0d got v=%b pc=%h i=%h want 1/%h/%h", c, valid0, ipc0, instr0, 8'(c-2), 9'(c-2));
            end
            if (valid0) $display("stream: c=%0d accept pc=%h instr=%h", c, ipc0, instr0);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        ready0 = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req0 === 1'b1) nreq++;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (nreq != 4) begin n_bad++; $display("FAIL bp_req_count got %0d want 4", nreq); end
        n_cmp++; if (req0 !== 1'b0) begin n_bad++; $display("FAIL bp_req_off got %b want 0", req0); end
        n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h00) begin n_bad++; $display("FAIL bp_hold got v=%b pc=%h want 1/00", valid0, ipc0); end
        ready0 = 1'b1;
        for (int c = 10; c < 16; c++) begin
            #1;
            n_cmp++;
            if (valid0 !== 1'b1 || ipc0 !== 8'(c-10)) begin
                n_bad++; $display("FAIL bp_drain c=%0d got v=%b pc=%h want 1/%h", c, valid0, ipc0, 8'(c-10));
            end
            if (c == 11) begin
                n_cmp++;
                if (req0 !== 1'b1 || addr0 !== 8'h04) begin n_bad++; $display("FAIL bp_resume got req=%b addr=%h want 1/04", req0, addr0); end
            end
            $display("backpressure: c=%0d accept pc=%h", c, ipc0);
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        ready0 = 1'b0;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            redir0 = 1'b0;
            if (c == 4) begin redir0 = 1'b1; target0 = 8'h40; end
            if (c == 9) begin redir0 = 1'b1; target0 = 8'h80; end
            if (c >= 7) ready0 = 1'b1;
            #1;
            case (c)
                4: begin n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h00) begin n_bad++; $display("FAIL rd_pre got v=%b pc=%h want 1/00", valid0, ipc0); end end
                5: begin
                    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rd_flush got v=%b want 0", valid0); end
                    n_cmp++; if (req0 !== 1'b1 || addr0 !== 8'h40) begin n_bad++; $display("FAIL rd_newreq got req=%b addr=%h want 1/40", req0, addr0); end
                end
                6: begin n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rd_stale got v=%b pc=%h want 0", valid0, ipc0); end end
                7: begin n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h40 || instr0 !== 9'h040) begin n_bad++; $display("FAIL rd_target got v=%b pc=%h i=%h want 1/40/040", valid0, ipc0, instr0); end end
                8: begin n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h41) begin n_bad++; $display("FAIL rd_next got v=%b pc=%h want 1/41", valid0, ipc0); end end
                9: begin n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h42) begin n_bad++; $display("FAIL rd2_pre got v=%b pc=%h want 1/42", valid0, ipc0); end end
                10: begin
                    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rd2_flush got v=%b want 0", valid0); end
                    n_cmp++; if (req0 !== 1'b1 || addr0 !== 8'h80) begin n_bad++; $display("FAIL rd2_newreq got req=%b addr=%h want 1/80", req0, addr0); end
                end
                11: begin n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rd2_epoch got v=%b pc=%h want 0", valid0, ipc0); end end
                12: begin n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h80) begin n_bad++; $display("FAIL rd2_target got v=%b pc=%h want 1/80", valid0, ipc0); end end
                default: ;
            endcase
            $display("redirect: c=%0d valid=%b pc=%h req=%b addr=%h", c, valid0, ipc0, req0, addr0);
            @(negedge clk);
        end
        redir0 = 1'b0;
    endtask

    task automatic test_halt();
        logic [7:0] max_addr = 8'h00;
        rom0[5] = 9'h1FF;
        ready0 = 1'b1;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req0 === 1'b1 && addr0 > max_addr) max_addr = addr0;
            if (c == 7) begin
                n_cmp++; if (valid0 !== 1'b1 || ipc0 !== 8'h05 || instr0 !== 9'h1FF) begin n_bad++; $display("FAIL halt_head got v=%b pc=%h i=%h want 1/05/1ff", valid0, ipc0, instr0); end
                n_cmp++; if (halt0 !== 1'b0) begin n_bad++; $display("FAIL halt_early got %b want 0", halt0); end
                n_cmp++; if (req0 !== 1'b0) begin n_bad++; $display("FAIL halt_stop got req=%b want 0", req0); end
            end
            if (c == 8) begin
                n_cmp++; if (halt0 !== 1'b1) begin n_bad++; $display("FAIL halt_set got %b want 1", halt0); end
                n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL halt_valid got %b want 0", valid0); end
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (max_addr !== 8'h06) begin n_bad++; $display("FAIL halt_maxaddr got %h want 06", max_addr); end
        n_cmp++; if (ct0 !== 16'd8) begin n_bad++; $display("FAIL halt_ct got %0d want 8", ct0); end
        n_cmp++; if (halt0 !== 1'b1) begin n_bad++; $display("FAIL halt_sticky got %b want 1", halt0); end
        $display("halt: max_addr=%h cycle_ct=%0d", max_addr, ct0);
        rom0[5] = 9'h005;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 4) begin
                n_cmp++; if (req1 !== 1'b1 || addr1 !== exp_addr[c]) begin n_bad++; $display("FAIL wrap_addr c=%0d got req=%b addr=%h want 1/%h", c, req1, addr1, exp_addr[c]); end
            end
            if (c >= 2) begin
                n_cmp++; if (valid1 !== 1'b1 || ipc1 !== exp_addr[c-2]) begin n_bad++; $display("FAIL wrap_pc c=%0d got v=%b pc=%h want 1/%h", c, valid1, ipc1, exp_addr[c-2]); end
            end
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req1 !== 1'b0 || valid1 !== 1'b0 || ct1 !== 16'd0 || addr1 !== 8'hFE) begin
            n_bad++; $display("FAIL wrap_async got req=%b v=%b ct=%0d addr=%h want 0/0/0/fe", req1, valid1, ct1, addr1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (c == 0) begin n_cmp++; if (req1 !== 1'b1 || addr1 !== 8'hFE) begin n_bad++; $display("FAIL wrap_restart got req=%b addr=%h want 1/fe", req1, addr1); end end
            if (c == 2) begin n_cmp++; if (valid1 !== 1'b1 || ipc1 !== 8'hFE) begin n_bad++; $display("FAIL wrap_repc got v=%b pc=%h want 1/fe", valid1, ipc1); end end
            @(negedge clk);
        end
        $display("wrap: restart checked");
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 25; c++) begin
            #1;
            if (c == 14) begin n_cmp++; if (ct2 !== 4'hE) begin n_bad++; $display("FAIL sat_14 got %h want e", ct2); end end
            if (c == 15) begin n_cmp++; if (ct2 !== 4'hF) begin n_bad++; $display("FAIL sat_15 got %h want f", ct2); end end
            if (c == 24) begin n_cmp++; if (ct2 !== 4'hF || halt2 !== 1'b0) begin n_bad++; $display("FAIL sat_hold got ct=%h halt=%b want f/0", ct2, halt2); end end
            @(negedge clk);
        end
        $display("saturate: cycle_ct=%h", ct2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom0[i] = 9'(i);
        ready0 = 1'b1; redir0 = 1'b0; target0 = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
